// File: rtl/inst_fetch_ctrl.sv
// Fetch-group controller: issues one 16-byte line request per group, slices up to
// three instructions from the returned line and presents them to the instruction FIFO.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_if,
  input  logic [31:0]      redirect_pc,
  output logic             req_icache,
  output logic [31:0]      addr_icache,
  input  logic             ready_icache,
  input  logic             valid_icache,
  input  logic [127:0]     rdata_icache,
  input  logic [2:0]       taken_bpu,
  input  logic [2:0][31:0] target_bpu,
  input  logic             full_ififo,
  output logic [2:0][31:0] pc_ifr,
  output logic [2:0][31:0] inst,
  output logic [2:0]       valid_inst_pre
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_DROP} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     npc_q, npc_d;
  logic [2:0][31:0] pc_ifr_q, pc_ifr_d;
  logic [2:0][31:0] inst_q, inst_d;
  logic [2:0]      mask_q, mask_d;

  logic [3:0][31:0] words;
  logic [1:0]      slot;
  int unsigned     nslots;
  logic [2:0][31:0] grp_pc, grp_inst;
  logic [2:0]      grp_mask;
  logic [31:0]     grp_npc;
  logic            taken_found;
  logic [31:0]     taken_tgt;
  logic [1:0]      widx;

  assign words = rdata_icache;
  assign slot  = pc_q[3:2];

  // Slice the returned line; the mask stops after the first predicted-taken slot.
  always_comb begin
    grp_pc      = '0;
    grp_inst    = '0;
    grp_mask    = '0;
    taken_found = 1'b0;
    taken_tgt   = '0;
    widx        = '0;
    case (slot)
      2'd2:    nslots = 2;
      2'd3:    nslots = 1;
      default: nslots = 3;
    endcase
    for (int unsigned i = 0; i < 3; i++) begin
      if (i < nslots) begin
        widx        = slot + 2'(i);
        grp_pc[i]   = pc_q + 32'(4 * i);
        grp_inst[i] = words[widx];
        if (!taken_found) begin
          grp_mask[i] = 1'b1;
          if (taken_bpu[i]) begin
            taken_found = 1'b1;
            taken_tgt   = {target_bpu[i][31:2], 2'b00};
          end
        end
      end
    end
    grp_npc = taken_found ? taken_tgt : pc_q + 32'(4 * nslots);
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    npc_d    = npc_q;
    pc_ifr_d = pc_ifr_q;
    inst_d   = inst_q;
    mask_d   = mask_q;
    case (state_q)
      S_REQ: begin
        if (flush_if) begin
          pc_d    = {redirect_pc[31:2], 2'b00};
          // The old request is accepted alongside the flush, so its response is still owed.
          state_d = ready_icache ? S_DROP : S_REQ;
        end else if (ready_icache) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush_if) begin
          pc_d    = {redirect_pc[31:2], 2'b00};
          state_d = valid_icache ? S_REQ : S_DROP;
        end else if (valid_icache) begin
          pc_ifr_d = grp_pc;
          inst_d   = grp_inst;
          mask_d   = grp_mask;
          npc_d    = grp_npc;
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (flush_if) begin
          pc_d    = {redirect_pc[31:2], 2'b00};
          state_d = S_REQ;
        end else if (!full_ififo) begin
          pc_d    = npc_q;
          state_d = S_REQ;
        end
      end
      default: begin
        if (flush_if) pc_d = {redirect_pc[31:2], 2'b00};
        if (valid_icache) state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= {RESET_PC[31:2], 2'b00};
      npc_q    <= '0;
      pc_ifr_q <= '0;
      inst_q   <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      pc_ifr_q <= pc_ifr_d;
      inst_q   <= inst_d;
      mask_q   <= mask_d;
    end
  end

  assign req_icache     = (state_q == S_REQ) && !rst;
  assign addr_icache    = {pc_q[31:4], 4'b0000};
  assign pc_ifr         = pc_ifr_q;
  assign inst           = inst_q;
  assign valid_inst_pre = (state_q == S_OUT) ? mask_q : 3'b000;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: hand-computed groups, redirects, backpressure and reset.
module tb_inst_fetch_ctrl;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_if;
  logic [31:0]      redirect_pc;
  logic             req_icache;
  logic [31:0]      addr_icache;
  logic             ready_icache;
  logic             valid_icache;
  logic [127:0]     rdata_icache;
  logic [2:0]       taken_bpu;
  logic [2:0][31:0] target_bpu;
  logic             full_ififo;
  logic [2:0][31:0] pc_ifr;
  logic [2:0][31:0] inst;
  logic [2:0]       valid_inst_pre;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] W0 = 32'hA000_0000, W1 = 32'hA111_1111,
                          W2 = 32'hA222_2222, W3 = 32'hA333_3333;

  inst_fetch_ctrl #(.RESET_PC(32'h1c00_0000)) dut (
    .clk(clk), .rst(rst), .flush_if(flush_if), .redirect_pc(redirect_pc),
    .req_icache(req_icache), .addr_icache(addr_icache), .ready_icache(ready_icache),
    .valid_icache(valid_icache), .rdata_icache(rdata_icache), .taken_bpu(taken_bpu),
    .target_bpu(target_bpu), .full_ififo(full_ififo), .pc_ifr(pc_ifr), .inst(inst),
    .valid_inst_pre(valid_inst_pre)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Handshake a request, then deliver a line one cycle later; ends in OUT.
  task automatic fetch(input logic [2:0] tk, input logic [31:0] tgt1);
    ready_icache = 1'b1;
    tick;
    ready_icache = 1'b0;
    valid_icache = 1'b1;
    rdata_icache = {W3, W2, W1, W0};
    taken_bpu    = tk;
    target_bpu   = {32'h0, tgt1, 32'h0};
    tick;
    valid_icache = 1'b0;
    taken_bpu    = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush_if = 0; redirect_pc = '0; ready_icache = 0; valid_icache = 0;
    rdata_icache = '0; taken_bpu = '0; target_bpu = '0; full_ififo = 0;
    tick; tick;
    n_chk++;
    if ({req_icache, valid_inst_pre, pc_ifr, inst} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b mask=%b pc_ifr=%h inst=%h, want all 0",
               req_icache, valid_inst_pre, pc_ifr, inst);
    end
    n_chk++;
    if (addr_icache !== 32'h1c00_0000) begin
      n_fail++; $display("FAIL reset_addr: got %h want 1c000000", addr_icache);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (req_icache !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_req: got %b want 1", req_icache);
    end
  endtask

  task automatic test_basic;
    ready_icache = 1'b1;
    tick;
    ready_icache = 1'b0;
    n_chk++;
    if ({req_icache, valid_inst_pre} !== 4'b0000) begin
      n_fail++; $display("FAIL wait_idle: req=%b mask=%b want 0/000", req_icache, valid_inst_pre);
    end
    valid_icache = 1'b1; rdata_icache = {W3, W2, W1, W0};
    tick;
    valid_icache = 1'b0;
    n_chk++;
    if (valid_inst_pre !== 3'b111) begin
      n_fail++; $display("FAIL basic_mask: got %b want 111", valid_inst_pre);
    end
    n_chk++;
    if (pc_ifr !== {32'h1c00_0008, 32'h1c00_0004, 32'h1c00_0000}) begin
      n_fail++; $display("FAIL basic_pc: got %h", pc_ifr);
    end
    n_chk++;
    if (inst !== {W2, W1, W0}) begin
      n_fail++; $display("FAIL basic_inst: got %h", inst);
    end
    tick;
    n_chk++;
    if ({req_icache, valid_inst_pre, addr_icache} !== {1'b1, 3'b000, 32'h1c00_0000}) begin
      n_fail++; $display("FAIL basic_next: req=%b mask=%b addr=%h want 1/000/1c000000",
                         req_icache, valid_inst_pre, addr_icache);
    end
  endtask

  task automatic test_slot3;
    fetch(3'b000, '0);
    n_chk++;
    if ({valid_inst_pre, pc_ifr, inst} !== {3'b001, 64'h0, 32'h1c00_000c, 64'h0, W3}) begin
      n_fail++; $display("FAIL slot3_group: mask=%b pc=%h inst=%h", valid_inst_pre, pc_ifr, inst);
    end
    tick;
    n_chk++;
    if ({req_icache, addr_icache} !== {1'b1, 32'h1c00_0010}) begin
      n_fail++; $display("FAIL slot3_next: req=%b addr=%h want 1/1c000010", req_icache, addr_icache);
    end
  endtask

  task automatic test_flush_req;
    flush_if = 1'b1; redirect_pc = 32'h1c00_0004;
    tick;
    flush_if = 1'b0;
    n_chk++;
    if ({req_icache, valid_inst_pre, addr_icache} !== {1'b1, 3'b000, 32'h1c00_0000}) begin
      n_fail++; $display("FAIL flush_req: req=%b mask=%b addr=%h want 1/000/1c000000",
                         req_icache, valid_inst_pre, addr_icache);
    end
  endtask

  task automatic test_taken;
    full_ififo = 1'b1;
    fetch(3'b010, 32'h1c00_0100);
    n_chk++;
    if ({valid_inst_pre, pc_ifr, inst} !==
        {3'b011, 32'h1c00_000c, 32'h1c00_0008, 32'h1c00_0004, W3, W2, W1}) begin
      n_fail++; $display("FAIL taken_group: mask=%b pc=%h inst=%h", valid_inst_pre, pc_ifr, inst);
    end
  endtask

  task automatic test_backpressure;
    for (int c = 0; c < 5; c++) begin
      tick;
      n_chk++;
      if ({req_icache, valid_inst_pre, pc_ifr[0], inst[1]} !==
          {1'b0, 3'b011, 32'h1c00_0004, W2}) begin
        n_fail++; $display("FAIL hold_cycle%0d: req=%b mask=%b pc0=%h inst1=%h",
                           c, req_icache, valid_inst_pre, pc_ifr[0], inst[1]);
      end
    end
    full_ififo = 1'b0;
    tick;
    n_chk++;
    if ({req_icache, valid_inst_pre, addr_icache} !== {1'b1, 3'b000, 32'h1c00_0100}) begin
      n_fail++; $display("FAIL hold_release: req=%b mask=%b addr=%h want 1/000/1c000100",
                         req_icache, valid_inst_pre, addr_icache);
    end
  endtask

  task automatic test_flush_wait;
    ready_icache = 1'b1;
    tick;
    ready_icache = 1'b0;
    flush_if = 1'b1; redirect_pc = 32'h1c00_0203;
    tick;
    flush_if = 1'b0;
    n_chk++;
    if ({req_icache, valid_inst_pre} !== 4'b0000) begin
      n_fail++; $display("FAIL drop_idle: req=%b mask=%b want 0/000", req_icache, valid_inst_pre);
    end
    tick;
    valid_icache = 1'b1;
    tick;
    valid_icache = 1'b0;
    n_chk++;
    if ({req_icache, valid_inst_pre, addr_icache} !== {1'b1, 3'b000, 32'h1c00_0200}) begin
      n_fail++; $display("FAIL drop_done: req=%b mask=%b addr=%h want 1/000/1c000200",
                         req_icache, valid_inst_pre, addr_icache);
    end
    fetch(3'b000, '0);
    n_chk++;
    if ({valid_inst_pre, pc_ifr[0], inst[0]} !== {3'b111, 32'h1c00_0200, W0}) begin
      n_fail++; $display("FAIL redirect_group: mask=%b pc0=%h inst0=%h",
                         valid_inst_pre, pc_ifr[0], inst[0]);
    end
    tick;
  endtask

  task automatic test_wrap;
    flush_if = 1'b1; redirect_pc = 32'hffff_fffe;
    tick;
    flush_if = 1'b0;
    fetch(3'b000, '0);
    n_chk++;
    if ({valid_inst_pre, pc_ifr[0], inst[0]} !== {3'b001, 32'hffff_fffc, W3}) begin
      n_fail++; $display("FAIL wrap_group: mask=%b pc0=%h inst0=%h", valid_inst_pre, pc_ifr[0], inst[0]);
    end
    tick;
    n_chk++;
    if (addr_icache !== 32'h0) begin
      n_fail++; $display("FAIL wrap_next: got %h want 00000000", addr_icache);
    end
  endtask

  task automatic test_reset_mid;
    ready_icache = 1'b1;
    tick;
    ready_icache = 1'b0;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({req_icache, valid_inst_pre, pc_ifr, inst, addr_icache} !== {196'h0, 32'h1c00_0000}) begin
      n_fail++; $display("FAIL reset_mid: req=%b mask=%b pc=%h inst=%h addr=%h",
                         req_icache, valid_inst_pre, pc_ifr, inst, addr_icache);
    end
    tick;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({req_icache, valid_inst_pre, addr_icache} !== {1'b1, 3'b000, 32'h1c00_0000}) begin
      n_fail++; $display("FAIL reset_mid_release: req=%b mask=%b addr=%h",
                         req_icache, valid_inst_pre, addr_icache);
    end
    fetch(3'b000, '0);
    n_chk++;
    if ({valid_inst_pre, pc_ifr[0]} !== {3'b111, 32'h1c00_0000}) begin
      n_fail++; $display("FAIL reset_mid_group: mask=%b pc0=%h", valid_inst_pre, pc_ifr[0]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_slot3;
    test_flush_req;
    test_taken;
    test_backpressure;
    test_flush_wait;
    test_wrap;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
